// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM state encodings, default timeout
// parameters and a small address-alignment helper.
package mem_access_stage_pkg;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } mem_state_t;

    localparam int TIMEOUT_CYC_DEFAULT = 16;
    localparam int CNT_W_DEFAULT       = 5;

    // Word accesses only: any nonzero low address bit is a fault.
    function automatic logic addr_misaligned(input logic [1:0] addr_lo);
        return (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting on the data-memory port; expired flags the last allowed
// cycle so the FSM can abort on the same edge.
module mem_timeout_counter
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = enable && (count_reg == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over a ready-handshaked data-memory port, stalls
// upstream while waiting, and registers MEM/WB results. Optional counters: MEM_PERF_CNT_EN.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_Mem_wr,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_RegWr,
    input  logic [31:0] MEM_ALUout,
    input  logic [31:0] MEM_rt_data,
    input  logic [4:0]  MEM_Write_register,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        WB_RegWr,
    output logic [4:0]  WB_Write_register,
    output logic [31:0] WB_wdata
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0] perf_mem_ops,
    output logic [31:0] perf_stall_cycles
`endif
);

    mem_state_t  state_reg, state_next;
    logic        wb_regwr_reg, wb_regwr_next;
    logic [4:0]  wb_reg_reg, wb_reg_next;
    logic [31:0] wb_wdata_reg, wb_wdata_next;
    logic        fault_reg, fault_next;

    logic mem_op;
    logic is_load;
    logic misaligned;
    logic in_access;
    logic timeout;
    logic access_done;
    logic stall_comb;
    logic timer_clear;

    // A request with both store and load bits set is executed as a store.
    assign mem_op      = MEM_Mem_wr | MEM_MemtoReg;
    assign is_load     = MEM_MemtoReg & ~MEM_Mem_wr;
    assign misaligned  = mem_op & addr_misaligned(MEM_ALUout[1:0]);
    assign in_access   = (state_reg == S_ACCESS);
    assign access_done = in_access & dmem_ready;
    assign timer_clear = ~in_access | dmem_ready | timeout;

    mem_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (in_access),
        .expired (timeout)
    );

    always_comb begin
        state_next    = state_reg;
        stall_comb    = 1'b0;
        fault_next    = 1'b0;
        wb_regwr_next = 1'b0;
        wb_reg_next   = wb_reg_reg;
        wb_wdata_next = wb_wdata_reg;
        case (state_reg)
            S_IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        fault_next = 1'b1;
                    end else begin
                        stall_comb = 1'b1;
                        state_next = S_ACCESS;
                    end
                end else begin
                    wb_regwr_next = MEM_RegWr;
                    wb_reg_next   = MEM_Write_register;
                    wb_wdata_next = MEM_ALUout;
                end
            end
            S_ACCESS: begin
                // Dropping the stall on ready lets EX/MEM advance on the completing edge.
                if (dmem_ready) begin
                    wb_regwr_next = MEM_RegWr & ~MEM_Mem_wr;
                    wb_reg_next   = MEM_Write_register;
                    wb_wdata_next = is_load ? dmem_rdata : MEM_ALUout;
                    state_next    = S_IDLE;
                end else if (timeout) begin
                    fault_next = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    stall_comb = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            wb_regwr_reg <= 1'b0;
            wb_reg_reg   <= '0;
            wb_wdata_reg <= '0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wb_regwr_reg <= wb_regwr_next;
            wb_reg_reg   <= wb_reg_next;
            wb_wdata_reg <= wb_wdata_next;
            fault_reg    <= fault_next;
        end
    end

    assign dmem_req          = in_access;
    assign dmem_we           = in_access & MEM_Mem_wr;
    assign dmem_addr         = in_access ? MEM_ALUout  : 32'h0;
    assign dmem_wdata        = in_access ? MEM_rt_data : 32'h0;
    assign mem_stall         = stall_comb;
    assign mem_fault         = fault_reg;
    assign WB_RegWr          = wb_regwr_reg;
    assign WB_Write_register = wb_reg_reg;
    assign WB_wdata          = wb_wdata_reg;

`ifdef MEM_PERF_CNT_EN
    logic [1:0] perf_inc;
    assign perf_inc = {stall_comb, access_done};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            logic [31:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (perf_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign perf_mem_ops      = g_perf[0].cnt_reg;
    assign perf_stall_cycles = g_perf[1].cnt_reg;
`else
    logic unused_done;
    assign unused_done = access_done;
`endif

endmodule
